f3m_mult_seq: RTL

Sequential trit-serial multiplier over GF(3^97), irreducible polynomial f(x) = x^97 + x^12 + 2. It is the operand-combining stage paired with the field inverter in the pairing datapath. It computes C = A·B mod f, for example the numerator times an inverse to form a quotient. A start/done handshake lets a controller chain it directly behind the inverter output.

---
 rtl/f3m_pkg.sv | 53 +++++
 rtl/f3m_mult_seq_if.sv | 25 ++
 rtl/f3m_mac_step.sv | 39 +++
 rtl/f3m_mult_seq.sv | 85 ++++++++
 4 files changed

// File: rtl/f3m_pkg.sv
// -----------------------------------------------------------------------------
// f3m_pkg
// Shared GF(3^97) definitions for the pairing datapath (multiplier, inverter,
// adder). Field polynomial f(x) = x^97 + x^12 + 2, so x^97 = 2x^12 + 1.
// Trit encoding inside an element: trit i = {e[2i+1], e[2i]}, 00=0, 01=1, 10=2.
// Code 11 is outside the contract; the helpers below stay deterministic for it.
// -----------------------------------------------------------------------------
package f3m_pkg;

    localparam int M     = 97;
    localparam int W     = 2 * M;
    localparam int TAP   = 12;
    localparam int CNT_W = 7;

    typedef logic [1:0]   trit_t;
    typedef logic [W-1:0] elem_t;

    localparam trit_t T0 = 2'b00;
    localparam trit_t T1 = 2'b01;
    localparam trit_t T2 = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Mod-3 sum of two trits, carry-free.
    function automatic trit_t trit_add(input trit_t a, input trit_t b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Negation mod 3 swaps 1 and 2, which is simply a swap of the bit pair.
    function automatic trit_t trit_neg(input trit_t a);
        return {a[0], a[1]};
    endfunction

    // Scale a trit by a trit multiplier t in {0,1,2}.
    function automatic trit_t trit_mul(input trit_t t, input trit_t a);
        trit_t r;
        case (t)
            T1:      r = a;
            T2:      r = trit_neg(a);
            default: r = T0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/f3m_mult_seq_if.sv
// -----------------------------------------------------------------------------
// f3m_mult_seq_if
// Start/done handshake bundle for the trit-serial multiplier.
//   start : request from the controller
//   A, B  : operands (multiplicand, multiplier)
//   busy  : operation in progress
//   done  : one-cycle completion pulse
//   C     : registered product
// master = controller side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface f3m_mult_seq_if;
    import f3m_pkg::*;

    logic  start;
    elem_t A;
    elem_t B;
    logic  busy;
    logic  done;
    elem_t C;

    modport master (output start, output A, output B,
                    input  busy,  input  done, input C);
    modport slave  (input  start, input  A,  input  B,
                    output busy,  output done, output C);
endinterface

// File: rtl/f3m_mac_step.sv
// -----------------------------------------------------------------------------
// f3m_mac_step
// One Horner iteration of the trit-serial multiply:
//   o_nextAcc = (i_acc * x mod f) + i_t * i_aQ
// Ports:
//   i_acc     : current accumulator
//   i_aQ      : latched multiplicand
//   i_t       : current multiplier trit
//   o_nextAcc : updated accumulator
// -----------------------------------------------------------------------------
module f3m_mac_step
    import f3m_pkg::*;
(
    input  elem_t i_acc,
    input  elem_t i_aQ,
    input  trit_t i_t,
    output elem_t o_nextAcc
);

    trit_t w_h;
    elem_t w_shifted;

    assign w_h = i_acc[W-1 -: 2];

    // Multiply by x, then fold the outgoing trit back using x^97 = 2x^12 + 1.
    // Trit 0 is empty after the shift, so it receives h directly; 2h is -h.
    // Each output trit sees at most two mod-3 adds (fold, then addend).
    always_comb begin
        w_shifted              = {i_acc[W-3:0], 2'b00};
        w_shifted[1:0]         = w_h;
        w_shifted[2*TAP +: 2]  = trit_add(w_shifted[2*TAP +: 2], trit_neg(w_h));
        o_nextAcc = '0;
        for (int i = 0; i < M; i++) begin
            o_nextAcc[2*i +: 2] = trit_add(w_shifted[2*i +: 2],
                                           trit_mul(i_t, i_aQ[2*i +: 2]));
        end
    end

endmodule

// File: rtl/f3m_mult_seq.sv
// -----------------------------------------------------------------------------
// f3m_mult_seq
// Sequential trit-serial multiplier over GF(3^97): C = A * B mod f.
// Multiplier trits are consumed MSB first (trit 96 down to trit 0), one per
// clock, so a product takes 97 RUN cycles after the start edge.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : start/A/B in, busy/done/C out (f3m_mult_seq_if slave)
// -----------------------------------------------------------------------------
module f3m_mult_seq
    import f3m_pkg::*;
(
    input  logic clk,
    input  logic reset,
    f3m_mult_seq_if.slave bus
);

    state_t            r_state;
    elem_t             r_aQ;
    elem_t             r_bSh;
    elem_t             r_acc;
    logic [CNT_W-1:0]  r_cnt;
    elem_t             r_c;
    logic              r_busy;
    logic              r_done;

    trit_t w_topTrit;
    elem_t w_nextAcc;

    assign w_topTrit = r_bSh[W-1 -: 2];

    f3m_mac_step u_macStep (
        .i_acc     (r_acc),
        .i_aQ      (r_aQ),
        .i_t       (w_topTrit),
        .o_nextAcc (w_nextAcc)
    );

    // Control and datapath registers. The counter is loaded with M-1 so the
    // cnt==0 edge is the 97th iteration; that edge also publishes the result
    // and returns to IDLE, which lets a start in the done cycle be accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_aQ    <= '0;
            r_bSh   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_aQ    <= bus.A;
                        r_bSh   <= bus.B;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(M - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_nextAcc;
                    r_bSh <= {r_bSh[W-3:0], 2'b00};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_c     <= w_nextAcc;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.C    = r_c;

endmodule
